restoring_divider_8bit: RTL and testbench

//  Sequential unsigned restoring divider: quotient and remainder of two WIDTH-bit operands.

---
 rtl/restoring_divider_8bit.sv | 111 +++++++++++
 tb/tb_restoring_divider_8bit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/restoring_divider_8bit.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// The trial subtraction is a ripple chain of full-subtractor cells, WIDTH+1 bits wide.

module restoring_divider_8bit_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);
  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module restoring_divider_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   r_sh, t, dx, r_nxt;
  logic [WIDTH+1:0] bw;
  logic [WIDTH-1:0] q_nxt;
  logic             borrow;

  // R never exceeds D after restore, so dropping R[WIDTH] on the shift loses nothing.
  assign r_sh  = {r[WIDTH-1:0], q[WIDTH-1]};
  assign dx    = {1'b0, d};
  assign bw[0] = 1'b0;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
    restoring_divider_8bit_sub_cell u_cell (
      .a    (r_sh[i]),
      .b    (dx[i]),
      .bin  (bw[i]),
      .diff (t[i]),
      .bout (bw[i+1])
    );
  end

  assign borrow = bw[WIDTH+1];
  assign r_nxt  = borrow ? r_sh : t;
  assign q_nxt  = {q[WIDTH-2:0], ~borrow};

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          if (divisor == '0) begin
            state       <= S_DONE;
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end else begin
            state <= S_RUN;
            q     <= dividend;
            d     <= divisor;
            r     <= '0;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          r   <= r_nxt;
          q   <= q_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state       <= S_DONE;
            quotient    <= q_nxt;
            remainder   <= r_nxt[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_restoring_divider_8bit.sv
// Directed bench for restoring_divider_8bit: latency, edge operands, divide-by-zero,
// ignored starts, back-to-back, reset mid-run, and a strided operand sweep.
module tb_restoring_divider_8bit;
  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] dividend, divisor;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  int checks = 0;
  int fails  = 0;

  restoring_divider_8bit #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Issue one op from IDLE and check latency, busy length, results, then return to IDLE.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b);
    int n, nb;
    logic [7:0] eq, er;
    eq = (b == 0) ? 8'hff : a / b;
    er = (b == 0) ? a : a % b;
    start = 1'b1; dividend = a; divisor = b;
    step();
    start = 1'b0; dividend = ~a; divisor = ~b;
    n = 1; nb = 0;
    while (!done && n < 20) begin
      if (busy) nb++;
      step(); n++;
    end
    if (busy) nb++;
    chk($sformatf("lat %0d/%0d", a, b), n, (b == 0) ? 1 : 9);
    chk($sformatf("busy %0d/%0d", a, b), nb, (b == 0) ? 1 : 9);
    chk($sformatf("quo %0d/%0d", a, b), quotient, eq);
    chk($sformatf("rem %0d/%0d", a, b), remainder, er);
    chk($sformatf("dbz %0d/%0d", a, b), div_by_zero, (b == 0));
    step();
    chk("idle_after_done", {busy, done}, 2'b00);
  endtask

  logic [7:0] va [6] = '{8'd255, 8'd5, 8'd255, 8'd254, 8'd0, 8'd81};
  logic [7:0] vb [6] = '{8'd1,   8'd9, 8'd255, 8'd128, 8'd3, 8'd9};

  initial begin
    int n, ndone;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_outs", {quotient, remainder, div_by_zero}, 0);
    rst = 1'b0;
    step();

    run_div(8'd100, 8'd7);
    foreach (va[i]) run_div(va[i], vb[i]);
    run_div(8'd200, 8'd0);
    run_div(8'd9, 8'd3);

    // Start pulse mid-RUN must be dropped, not queued.
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    step();
    start = 1'b0;
    step(); step();
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    step();
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        ndone++;
        chk("ign_quo", quotient, 14);
        chk("ign_rem", remainder, 2);
      end
      step();
    end
    chk("ign_ndone", ndone, 1);
    chk("ign_idle", busy, 0);

    // Start held high: second op accepted from the IDLE cycle after DONE.
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    step();
    dividend = 8'd81; divisor = 8'd9;
    n = 1;
    while (!done && n < 20) begin step(); n++; end
    chk("b2b_lat1", n, 9);
    chk("b2b_quo1", quotient, 14);
    step(); n = 1;
    while (!done && n < 20) begin step(); n++; end
    start = 1'b0;
    chk("b2b_period", n, 10);
    chk("b2b_quo2", quotient, 9);
    chk("b2b_rem2", remainder, 0);
    step();

    // Reset in the middle of RUN discards everything.
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    step();
    start = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_outs", {done, quotient, remainder, div_by_zero}, 0);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (done || busy) ndone++;
      step();
    end
    chk("mid_rst_quiet", ndone, 0);
    run_div(8'd81, 8'd9);

    // Reset wins over start.
    rst = 1'b1; start = 1'b1; dividend = 8'd10; divisor = 8'd0;
    step();
    chk("rst_start_busy", busy, 0);
    chk("rst_start_outs", {quotient, remainder, div_by_zero}, 0);
    rst = 1'b0; start = 1'b0;
    step();

    for (int a = 0; a < 256; a += 37)
      for (int b = 0; b < 256; b += 29)
        run_div(8'(a), 8'(b));
    run_div(8'd255, 8'd254);
    run_div(8'd128, 8'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
